// File: rtl/control_fsm.sv
// Multicycle RV32I control unit: fetch/decode/execute FSM with memory ready handshake and timeout.
// Optional CONTROL_TRAP_EN: undefined opcodes park the FSM in TRAP and raise illegal_o until reset.
module control_fsm #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 5
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] instr_i,
  input  logic        zero_i,
  input  logic        carry_i,
  input  logic        sign_i,
  input  logic        overflow_i,
  input  logic        mem_ready_i,
  output logic        mem_req_o,
  output logic        adr_src_o,
  output logic        mem_write_o,
  output logic        ir_write_o,
  output logic        pc_write_o,
  output logic        reg_write_o,
  output logic [1:0]  result_src_o,
  output logic [1:0]  alu_src_a_o,
  output logic [1:0]  alu_src_b_o,
  output logic [1:0]  alu_op_o,
  output logic        bus_err_o,
  output logic [3:0]  state_o
`ifdef CONTROL_TRAP_EN
  , output logic      illegal_o
`endif
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC   = 4'd2,
    S_MEM    = 4'd3,
    S_MEMWB  = 4'd4,
    S_ALUWB  = 4'd5,
    S_TRAP   = 4'd6
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam bit              TO_EN   = (MEM_TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [6:0] opcode_s;
  logic [2:0] funct3_s;
  logic       is_store_s;
  logic       timeout_s;
  logic       unused_instr_s;

  logic       mem_req_s, adr_src_s, mem_write_s, ir_write_s, pc_write_s, reg_write_s, bus_err_s;
  logic [1:0] result_src_s, alu_src_a_s, alu_src_b_s, alu_op_s;

  function automatic logic br_taken(input logic [2:0] f3, input logic z, input logic c,
                                    input logic s, input logic v);
    case (f3)
      3'b000:  return z;
      3'b001:  return ~z;
      3'b100:  return s ^ v;
      3'b101:  return ~(s ^ v);
      3'b110:  return c;
      3'b111:  return ~c;
      default: return 1'b0;
    endcase
  endfunction

  assign opcode_s       = instr_i[6:0];
  assign funct3_s       = instr_i[14:12];
  assign is_store_s     = (opcode_s == OP_STORE);
  assign timeout_s      = TO_EN && (cnt_q == TO_LAST) && !mem_ready_i;
  assign unused_instr_s = ^{instr_i[31:15], instr_i[11:7]};

  // Next-state, wait counter and datapath controls decoded from the current state.
  always_comb begin
    state_d      = state_q;
    cnt_d        = '0;
    mem_req_s    = 1'b0;
    adr_src_s    = 1'b0;
    mem_write_s  = 1'b0;
    ir_write_s   = 1'b0;
    pc_write_s   = 1'b0;
    reg_write_s  = 1'b0;
    bus_err_s    = 1'b0;
    result_src_s = 2'b00;
    alu_src_a_s  = 2'b00;
    alu_src_b_s  = 2'b00;
    alu_op_s     = 2'b00;
    case (state_q)
      S_FETCH: begin
        mem_req_s = 1'b1;
        if (mem_ready_i) begin
          ir_write_s   = 1'b1;
          pc_write_s   = 1'b1;
          alu_src_b_s  = 2'b10;
          result_src_s = 2'b10;
          state_d      = S_DECODE;
        end else if (timeout_s) begin
          bus_err_s = 1'b1;
          state_d   = S_FETCH;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DECODE: begin
        alu_src_a_s = 2'b01;
        alu_src_b_s = 2'b01;
        state_d     = S_EXEC;
      end
      S_EXEC: begin
        case (opcode_s)
          OP_LOAD, OP_STORE: begin
            alu_src_a_s = 2'b10;
            alu_src_b_s = 2'b01;
            state_d     = S_MEM;
          end
          OP_R: begin
            alu_src_a_s = 2'b10;
            alu_op_s    = 2'b10;
            state_d     = S_ALUWB;
          end
          OP_I: begin
            alu_src_a_s = 2'b10;
            alu_src_b_s = 2'b01;
            alu_op_s    = 2'b10;
            state_d     = S_ALUWB;
          end
          OP_JAL: begin
            alu_src_a_s = 2'b01;
            alu_src_b_s = 2'b10;
            pc_write_s  = 1'b1;
            state_d     = S_ALUWB;
          end
          OP_BRANCH: begin
            alu_src_a_s = 2'b10;
            alu_op_s    = 2'b01;
            pc_write_s  = br_taken(funct3_s, zero_i, carry_i, sign_i, overflow_i);
            state_d     = S_FETCH;
          end
          OP_LUI: begin
            alu_src_b_s  = 2'b01;
            alu_op_s     = 2'b11;
            result_src_s = 2'b10;
            reg_write_s  = 1'b1;
            state_d      = S_FETCH;
          end
          OP_AUIPC: begin
            alu_src_a_s  = 2'b01;
            alu_src_b_s  = 2'b01;
            result_src_s = 2'b10;
            reg_write_s  = 1'b1;
            state_d      = S_FETCH;
          end
          default: begin
`ifdef CONTROL_TRAP_EN
            state_d = S_TRAP;
`else
            state_d = S_FETCH;
`endif
          end
        endcase
      end
      S_MEM: begin
        mem_req_s = 1'b1;
        adr_src_s = 1'b1;
        if (mem_ready_i) begin
          mem_write_s = is_store_s;
          state_d     = is_store_s ? S_FETCH : S_MEMWB;
        end else if (timeout_s) begin
          bus_err_s = 1'b1;
          state_d   = S_FETCH;
        end else begin
          mem_write_s = is_store_s;
          cnt_d       = cnt_q + CNT_W'(1);
        end
      end
      S_MEMWB: begin
        result_src_s = 2'b01;
        reg_write_s  = 1'b1;
        state_d      = S_FETCH;
      end
      S_ALUWB: begin
        reg_write_s = 1'b1;
        state_d     = S_FETCH;
      end
      S_TRAP: begin
`ifdef CONTROL_TRAP_EN
        state_d = S_TRAP;
`else
        state_d = S_FETCH;
`endif
      end
      default: state_d = S_FETCH;
    endcase
  end

  // State and wait-counter registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Reset forces every enable and the memory request low so an in-flight access aborts cleanly.
  assign mem_req_o    = mem_req_s   & ~rst_i;
  assign mem_write_o  = mem_write_s & ~rst_i;
  assign ir_write_o   = ir_write_s  & ~rst_i;
  assign pc_write_o   = pc_write_s  & ~rst_i;
  assign reg_write_o  = reg_write_s & ~rst_i;
  assign bus_err_o    = bus_err_s   & ~rst_i;
  assign adr_src_o    = adr_src_s;
  assign result_src_o = result_src_s;
  assign alu_src_a_o  = alu_src_a_s;
  assign alu_src_b_o  = alu_src_b_s;
  assign alu_op_o     = alu_op_s;
  assign state_o      = state_q;
`ifdef CONTROL_TRAP_EN
  assign illegal_o    = (state_q == S_TRAP);
`endif

endmodule
